// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes arrive over a valid/ready handshake into a small FIFO and are sent LSB first.
// Latency: io_tx falls one cycle after a byte is accepted while idle. tx_ready drops only while the FIFO is full.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          io_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [2:0]          bit_idx, bit_n;
  logic [7:0]          shift, shift_n;
  logic                line_n;
  logic                pop, push, bit_end;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  assign tx_ready   = (count != FULL);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);
  assign tx_done    = (state == STOP) && bit_end;

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    line_n  = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n = shift >> 1;
            bit_n   = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          // Chain straight into the next start bit so queued frames have no idle gap
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // io_tx is registered, so it is driven from the state being entered
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      io_tx    <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      io_tx    <= line_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a CLKS_PER_BIT=4/FIFO_DEPTH=4 instance for most cases, a CLKS_PER_BIT=2 instance for the baud boundary.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data, data2;
  logic       tx_valid, valid2;
  logic       tx_ready, io_tx, busy, tx_done;
  logic [2:0] fifo_count;
  logic       ready2, io_tx2, busy2, done2;
  logic [3:0] count2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .io_tx(io_tx), .busy(busy), .fifo_count(fifo_count), .tx_done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
    .io_tx(io_tx2), .busy(busy2), .fifo_count(count2), .tx_done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? io_tx2 : io_tx;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? done2 : tx_done;
  endfunction

  // Entered on the first cycle of the start bit; returns on the cycle after the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] b, input int c, input bit sel, input string tag);
    logic exp_bit;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b[k-1];
      for (int j = 0; j < c; j++) begin
        chk({tag, "_line"}, 8'(line_of(sel)), 8'(exp_bit));
        chk({tag, "_done"}, 8'(done_of(sel)), 8'((k == 9) && (j == c - 1)));
        step();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a10, a15, lows, guard;
    a10 = 0; a15 = 0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; valid2 = 1'b0; data2 = 8'h00;
    #2;
    chk("rst_io_tx", 8'(io_tx), 8'd1);
    chk("rst_ready", 8'(tx_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_count", 8'(fifo_count), 8'd0);
    chk("rst_done", 8'(tx_done), 8'd0);
    chk("rst_io_tx2", 8'(io_tx2), 8'd1);
    step(); step();
    reset = 1'b0;
    step();

    // single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    step();
    tx_valid = 1'b0;
    chk("t1_cnt_push", 8'(fifo_count), 8'd1);
    chk("t1_line_idle", 8'(io_tx), 8'd1);
    step();
    chk("t1_cnt_pop", 8'(fifo_count), 8'd0);
    chk("t1_busy_on", 8'(busy), 8'd1);
    check_frame(8'hA5, 4, 1'b0, "t1");
    chk("t1_busy_off", 8'(busy), 8'd0);
    chk("t1_line_end", 8'(io_tx), 8'd1);

    // back-to-back 0x00 then 0xFF
    chk("t2_cnt_0", 8'(fifo_count), 8'd0);
    tx_valid = 1'b1; tx_data = 8'h00;
    step();
    tx_data = 8'hFF;
    step();
    tx_valid = 1'b0;
    chk("t2_cnt_1", 8'(fifo_count), 8'd1);
    check_frame(8'h00, 4, 1'b0, "t2a");
    chk("t2_cnt_after_pop", 8'(fifo_count), 8'd0);
    check_frame(8'hFF, 4, 1'b0, "t2b");
    chk("t2_busy_off", 8'(busy), 8'd0);

    // full FIFO with 0x10..0x15 held on tx_valid
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          tx_valid = 1'b1;
          tx_data  = 8'h10 + 8'(i);
          guard = 0;
          while (!tx_ready && guard < 200) begin
            step();
            guard++;
          end
          chk("t3_ready_wait", 8'(tx_ready), 8'd1);
          step();
          if (i == 0) a10 = cyc;
          if (i == 4) begin
            chk("t3_full_cnt", 8'(fifo_count), 8'd4);
            chk("t3_full_ready", 8'(tx_ready), 8'd0);
          end
          if (i == 5) a15 = cyc;
        end
        tx_valid = 1'b0;
      end
      begin
        step();
        chk("t3_line_pre", 8'(io_tx), 8'd1);
        step();
        for (int i = 0; i < 6; i++) check_frame(8'h10 + 8'(i), 4, 1'b0, "t3");
      end
    join
    chk("t3_accept_gap", 8'(a15 - a10), 8'd42);
    chk("t3_busy_off", 8'(busy), 8'd0);

    // push on the same edge as an end-of-stop pop
    tx_valid = 1'b1; tx_data = 8'h5A;
    step();
    tx_data = 8'h96;
    step();
    tx_valid = 1'b0;
    fork
      begin
        check_frame(8'h5A, 4, 1'b0, "t4a");
        check_frame(8'h96, 4, 1'b0, "t4b");
        check_frame(8'hC3, 4, 1'b0, "t4c");
      end
      begin
        repeat (39) step();
        tx_valid = 1'b1; tx_data = 8'hC3;
        chk("t4_cnt_before", 8'(fifo_count), 8'd1);
        step();
        tx_valid = 1'b0;
        chk("t4_cnt_after", 8'(fifo_count), 8'd1);
      end
    join
    chk("t4_busy_off", 8'(busy), 8'd0);

    // reset during data bit 3 of 0x3C with two bytes queued
    tx_valid = 1'b1; tx_data = 8'h3C;
    step();
    tx_data = 8'h11;
    step();
    tx_data = 8'h22;
    step();
    tx_valid = 1'b0;
    chk("t5_cnt_queued", 8'(fifo_count), 8'd2);
    repeat (16) step();
    chk("t5_busy_mid", 8'(busy), 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_line", 8'(io_tx), 8'd1);
    chk("t5_rst_cnt", 8'(fifo_count), 8'd0);
    chk("t5_rst_busy", 8'(busy), 8'd0);
    chk("t5_rst_ready", 8'(tx_ready), 8'd1);
    step(); step();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!io_tx || busy) lows++;
    end
    chk("t5_quiet", 8'(lows), 8'd0);
    tx_valid = 1'b1; tx_data = 8'h81;
    step();
    tx_valid = 1'b0;
    step();
    check_frame(8'h81, 4, 1'b0, "t5");

    // baud boundary on the two-clock instance
    valid2 = 1'b1; data2 = 8'h80;
    step();
    valid2 = 1'b0;
    chk("t6_cnt_push", 8'(count2), 8'd1);
    step();
    check_frame(8'h80, 2, 1'b1, "t6");
    chk("t6_busy_off", 8'(busy2), 8'd0);
    chk("t6_line_end", 8'(io_tx2), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the `cpu` core: the transmit counterpart of the `io_rx` receive line. It accepts bytes from the core side over a valid/ready handshake and buffers them in a small FIFO. It serialises each byte onto `io_tx` as an 8N1 frame: one start bit, 8 data bits LSB first, one stop bit, no parity. The line idles high. It sits beside the core's I/O logic and drives the board's TX pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit, which is 115200 baud at 100 MHz. Legal range ≥ 2.
- `FIFO_DEPTH`, default 8: byte FIFO depth. Must be a power of 2 and ≥ 2.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `tx_data` in, 8: byte to send. Sampled when `tx_valid && tx_ready`.
- `tx_valid` in, 1: producer has a byte.
- `tx_ready` out, 1: FIFO can accept a byte this cycle.
- `io_tx` out, 1: serial line, registered output.
- `busy` out, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` out, $clog2(FIFO_DEPTH)+1: bytes currently queued, excluding the byte being shifted.
- `tx_done` out, 1: one-cycle pulse on the last cycle of each stop bit.

## Operation
- **FIFO**
  - Circular buffer with write pointer, read pointer and count.
  - Push when `tx_valid && tx_ready`.
  - `tx_ready = (fifo_count != FIFO_DEPTH)`. It depends only on registered count.
  - No push is accepted while full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE**
  - `io_tx` = 1.
  - If FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START.
- **START**
  - `io_tx` = 0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- **DATA**
  - `io_tx` = shift[0] for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- **STOP**
  - `io_tx` = 1 for CLKS_PER_BIT cycles.
  - `tx_done` pulses on the final cycle.
  - At the end of STOP: if FIFO is non-empty, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- **Baud counter**
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
- **Bit index:** 3 bits, range 0..7.
- **`busy`:** `(state != IDLE) || (fifo_count != 0)`.
- **Data stability:** `tx_data` changes after acceptance never affect a queued or in-flight byte.

## Timing
- **Reset values** (asynchronous assert, effective immediately):
  - `io_tx` = 1, `tx_ready` = 1, `busy` = 0, `fifo_count` = 0, `tx_done` = 0.
  - State = IDLE; pointers, counters and shift register = 0.
- **Reset mid-frame:** aborts the frame. The line returns high immediately and the FIFO contents are discarded.
- **Latency from idle:** a byte accepted at edge N is in the FIFO after N. The FSM pops at edge N+1, and `io_tx` goes low starting N+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles, start-bit falling edge to end of stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **`fifo_count` on pop:** decrements on the pop edge, i.e. the edge entering START.
- **`tx_ready`:** may be held low for up to 10·CLKS_PER_BIT cycles when the FIFO is full. The producer must hold `tx_valid` and `tx_data` until accepted.

## Test plan
- **Single byte.** CLKS_PER_BIT=4, push 0xA5 while idle.
  - `io_tx` low 4 cycles starting 1 cycle after acceptance.
  - Then data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then high 4 cycles; `tx_done` pulses once on the last of those cycles.
  - Then `busy` = 0.
- **Back-to-back.** Push 0x00 then 0xFF on consecutive cycles.
  - Two frames with no idle cycle between the stop bit of 0x00 and the start bit of 0xFF.
  - `fifo_count` reads 0→1→0 around the second pop.
- **Full FIFO.** FIFO_DEPTH=4, hold `tx_valid` with 0x10..0x15.
  - Byte 0x10 pops immediately; 0x11..0x14 fill the FIFO and `tx_ready` drops with `fifo_count` = 4.
  - 0x15 is accepted on the cycle after the 0x11 pop.
  - Line output order is 0x10..0x15.
- **Simultaneous push/pop.** Push a byte on the same edge as an end-of-STOP pop.
  - `fifo_count` unchanged.
  - Both bytes transmitted in order.
- **Reset mid-frame.** Assert `reset` during DATA bit 3 of 0x3C with 2 bytes queued.
  - `io_tx` = 1 and `fifo_count` = 0 immediately.
  - After release there is no output until a new push.
- **Baud boundary.** CLKS_PER_BIT=2, push 0x80.
  - Each bit lasts exactly 2 cycles; the total frame is 20 cycles.
